// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for counters and pointer synchronisers.
// Functions take 32-bit arguments; narrower callers zero-extend and slice.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } cnt_op_e;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
        logic [GRAY_MAX_WIDTH-1:0] b;
        logic                      acc;
        acc = 1'b0;
        for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary conversion as an MSB-first prefix XOR.
// Zero latency, no flow control.
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic acc;

    always_comb begin
        acc   = 1'b0;
        bin_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with clear, Gray-coded load, wrap/saturate and registered flags.
// All outputs update one cycle after the controlling inputs; no backpressure.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] bin,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;
    cnt_op_e          op;

    logic [GRAY_MAX_WIDTH-1:0] bin_ext;
    logic [GRAY_MAX_WIDTH-1:0] gray_full;
    logic                      unused_gray_hi;

    gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .gray_i (load_gray),
        .bin_o  (load_bin)
    );

    always_comb begin
        op = OP_HOLD;
        if (clr)       op = OP_CLR;
        else if (load) op = OP_LOAD;
        else if (en)   op = up_dn ? OP_UP : OP_DOWN;
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        case (op)
            OP_CLR:  bin_d = '0;
            OP_LOAD: bin_d = load_bin;
            OP_UP: begin
                if (bin_q != MAX_VAL) begin
                    bin_d = bin_q + ONE;
                end else if (!SATURATE) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end
            OP_DOWN: begin
                if (bin_q != '0) begin
                    bin_d = bin_q - ONE;
                end else if (!SATURATE) begin
                    bin_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
            default: ;
        endcase

        bin_ext                = '0;
        bin_ext[WIDTH-1:0]     = bin_d;
        gray_full              = bin2gray(bin_ext);
        // Load passes the caller's Gray word through untouched.
        q_d      = (op == OP_LOAD) ? load_gray : gray_full[WIDTH-1:0];
        at_max_d = (bin_d == MAX_VAL);
        at_min_d = (bin_d == '0);
    end

    assign unused_gray_hi = ^gray_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            q_q      <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            wrap_q   <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            q_q      <= q_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
            wrap_q   <= wrap_d;
        end
    end

    assign q      = q_q;
    assign qb     = ~q_q;
    assign bin    = bin_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed plus random bench for three counter flavours sharing one stimulus stream.
// Reference model tracks counts as plain integers and looks up Gray codes by search.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_gray = '0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;

    logic [4:0] q0, qb0, bin0;
    logic       amax0, amin0, wrap0;
    logic [4:0] q1, qb1, bin1;
    logic       amax1, amin1, wrap1;
    logic [0:0] q2, qb2, bin2;
    logic       amax2, amin2, wrap2;

    int checks = 0;
    int errors = 0;

    int mbin  [3];
    int mwrap [3];
    int mw    [3] = '{5, 5, 1};
    int msat  [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(5), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_gray(load_gray),
        .en(en), .up_dn(up_dn), .q(q0), .qb(qb0), .bin(bin0),
        .at_max(amax0), .at_min(amin0), .wrap(wrap0)
    );

    gray_updown_counter #(.WIDTH(5), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_gray(load_gray),
        .en(en), .up_dn(up_dn), .q(q1), .qb(qb1), .bin(bin1),
        .at_max(amax1), .at_min(amin1), .wrap(wrap1)
    );

    gray_updown_counter #(.WIDTH(1), .SATURATE(1'b0)) dut_w1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_gray(load_gray[0:0]),
        .en(en), .up_dn(up_dn), .q(q2), .qb(qb2), .bin(bin2),
        .at_max(amax2), .at_min(amin2), .wrap(wrap2)
    );

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    // Inverse Gray by exhaustive search over the code space.
    function automatic int bin_of_gray(input int g, input int w);
        for (int v = 0; v < (1 << w); v++)
            if (gray_of(v) == g) return v;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mbin[k]  = 0;
            mwrap[k] = 0;
        end
    endtask

    task automatic model_step();
        int maxv;
        for (int k = 0; k < 3; k++) begin
            maxv     = (1 << mw[k]) - 1;
            mwrap[k] = 0;
            if (clr) begin
                mbin[k] = 0;
            end else if (load) begin
                mbin[k] = bin_of_gray(int'(load_gray) & maxv, mw[k]);
            end else if (en) begin
                if (up_dn) begin
                    if (mbin[k] < maxv) mbin[k] = mbin[k] + 1;
                    else if (msat[k] == 0) begin mbin[k] = 0; mwrap[k] = 1; end
                end else begin
                    if (mbin[k] > 0) mbin[k] = mbin[k] - 1;
                    else if (msat[k] == 0) begin mbin[k] = maxv; mwrap[k] = 1; end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input int k, input logic [31:0] oq, input logic [31:0] oqb,
                             input logic [31:0] obin, input logic omax, input logic omin,
                             input logic owrap);
        int maxv;
        string p;
        maxv = (1 << mw[k]) - 1;
        p = $sformatf("dut%0d", k);
        chk({p, ".bin"},    obin,  32'(mbin[k]));
        chk({p, ".q"},      oq,    32'(gray_of(mbin[k])));
        chk({p, ".qb"},     oqb,   32'(~gray_of(mbin[k]) & maxv));
        chk({p, ".at_max"}, {31'b0, omax},  32'(mbin[k] == maxv));
        chk({p, ".at_min"}, {31'b0, omin},  32'(mbin[k] == 0));
        chk({p, ".wrap"},   {31'b0, owrap}, 32'(mwrap[k]));
    endtask

    task automatic check_all();
        check_one(0, 32'(q0), 32'(qb0), 32'(bin0), amax0, amin0, wrap0);
        check_one(1, 32'(q1), 32'(qb1), 32'(bin1), amax1, amin1, wrap1);
        check_one(2, 32'(q2), 32'(qb2), 32'(bin2), amax2, amin2, wrap2);
    endtask

    task automatic cycle(input logic c, input logic l, input logic [4:0] lg,
                         input logic e, input logic u);
        clr = c; load = l; load_gray = lg; en = e; up_dn = u;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic [4:0] prev_q0;
        logic [0:0] prev_q2;

        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Full up sweep through the wrap, one bit changing per step.
        for (int i = 0; i < 32; i++) begin
            prev_q0 = q0;
            prev_q2 = q2;
            cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
            chk("hamming_w5", 32'($countones(prev_q0 ^ q0)), 32'd1);
            chk("hamming_w1", 32'($countones(prev_q2 ^ q2)), 32'd1);
        end
        chk("sweep_end_q", 32'(q0), 32'd0);

        // Down from zero wraps to max.
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("down_wrap_q", 32'(q0), 32'b10000);
        chk("down_wrap_flag", 32'(wrap0), 32'd1);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("wrap_one_cycle", 32'(wrap0), 32'd0);

        // Saturation at max.
        cycle(1'b0, 1'b1, 5'b10000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("sat_hold_q", 32'(q1), 32'b10000);

        // Load wins over en, then counts from the loaded value.
        cycle(1'b0, 1'b1, 5'b01101, 1'b1, 1'b1);
        chk("load_bin", 32'(bin0), 32'd9);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("load_next_q", 32'(q0), 32'b01111);

        // Clear beats load and en.
        cycle(1'b1, 1'b1, 5'b10101, 1'b1, 1'b1);
        chk("clr_prio_bin", 32'(bin0), 32'd0);

        // Async reset mid-count at bin=17.
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("pre_rst_bin", 32'(bin0), 32'd17);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_qb", 32'(qb0), 32'b11111);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);

        // Random mix including direction reversals and occasional async reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst = 1'b0;
            end
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 5'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
